md_sched: RTL and testbench

- Multi-cycle multiply/divide sequencer with HI/LO registers, placed in E stage beside the ALU.
- Accepts one MD operation per start, holds busy for a fixed cycle count, then commits HI/LO.
- Produces the MD stall request that the D-stage hazard logic ORs into the pipeline Stall.
- MFHI/MFLO read the hi/lo outputs directly in E stage.

---
 rtl/md_sched_if.sv | 16 +
 rtl/md_sched.sv | 103 ++++++++++
 tb/tb_md_sched.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/md_sched_if.sv
// E-stage multiply/divide handshake: op/operands in from the pipeline,
// busy/stall and the HI/LO registers back out.
interface md_sched_if;
  logic [2:0]  op;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_md_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output op, start, a, b, d_md_use, input busy, stall, hi, lo);
  modport slave  (input op, start, a, b, d_md_use, output busy, stall, hi, lo);
endinterface

// File: rtl/md_sched.sv
// Multi-cycle MULT/DIV sequencer: the result is computed at start, held pending
// for a fixed busy count, then committed to HI/LO.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_sched_if.slave md
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MC = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DC = CW'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] phi_q, phi_d, plo_q, plo_d;
  logic        pok_q, pok_d;

  logic signed [63:0] smul;
  logic [63:0] umul;
  logic [31:0] dvs, sq, sr, uq, ur;
  logic        sovf;

  always_comb begin
    smul = $signed({{32{md.a[31]}}, md.a}) * $signed({{32{md.b[31]}}, md.b});
    umul = {32'b0, md.a} * {32'b0, md.b};
    // Divisor forced nonzero so the dividers never see 0; the result is discarded anyway.
    dvs  = (md.b == 32'd0) ? 32'd1 : md.b;
    sovf = (md.a == 32'h8000_0000) && (md.b == 32'hFFFF_FFFF);
    sq   = sovf ? 32'h8000_0000 : 32'($signed(md.a) / $signed(dvs));
    sr   = sovf ? 32'd0         : 32'($signed(md.a) % $signed(dvs));
    uq   = md.a / dvs;
    ur   = md.a % dvs;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    pok_d   = pok_q;
    case (state_q)
      IDLE: begin
        if (md.start && (md.op >= 3'd1) && (md.op <= 3'd4)) begin
          state_d = RUN;
          pok_d   = 1'b1;
          case (md.op)
            3'd1: begin cnt_d = MC; {phi_d, plo_d} = smul; end
            3'd2: begin cnt_d = MC; {phi_d, plo_d} = umul; end
            3'd3: begin cnt_d = DC; phi_d = sr; plo_d = sq; pok_d = (md.b != 32'd0); end
            default: begin cnt_d = DC; phi_d = ur; plo_d = uq; pok_d = (md.b != 32'd0); end
          endcase
        end else if (md.op == 3'd5) begin
          hi_d = md.a;
        end else if (md.op == 3'd6) begin
          lo_d = md.a;
        end
      end
      default: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          if (pok_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      pok_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      pok_q   <= pok_d;
    end
  end

  assign md.busy  = (state_q == RUN);
  assign md.stall = md.d_md_use & (md.busy | md.start);
  assign md.hi    = hi_q;
  assign md.lo    = lo_q;
endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed cases plus a randomized run
// checked against a sign/magnitude arithmetic model.
module tb_md_sched;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [31:0] exp_hi, exp_lo;

  md_sched_if mif();
  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .md(mif.slave));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    mif.op = op; mif.start = 1'b1; mif.a = a; mif.b = b;
    tick();
    mif.op = 3'd0; mif.start = 1'b0;
  endtask

  function automatic int ncyc(input logic [2:0] op);
    return (op <= 3'd2) ? 5 : 10;
  endfunction

  // Reference: products in 64-bit arithmetic, signed divide via magnitudes.
  function automatic void ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] h, inout logic [31:0] l);
    longint sp;
    logic [63:0] up;
    logic [31:0] ma, mb, q, r;
    case (op)
      3'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); {h, l} = sp; end
      3'd2: begin up = {32'b0, a} * {32'b0, b}; {h, l} = up; end
      3'd3: if (b != 0) begin
        ma = a[31] ? -a : a;
        mb = b[31] ? -b : b;
        q = ma / mb; r = ma % mb;
        l = (a[31] ^ b[31]) ? -q : q;
        h = a[31] ? -r : r;
      end
      3'd4: if (b != 0) begin l = a / b; h = a % b; end
      default: ;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1; mif.d_md_use = 1'b1;
    tick();
    n_chk++; if (mif.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %h want 0", mif.busy); end
    n_chk++; if (mif.hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", mif.hi); end
    n_chk++; if (mif.lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", mif.lo); end
    n_chk++; if (mif.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %h want 0", mif.stall); end
    reset = 1'b0;
    tick();
    exp_hi = 0; exp_lo = 0;
  endtask

  task automatic test_arith();
    logic [2:0]  t_op[4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [31:0] t_a[4]  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7};
    logic [31:0] t_b[4]  = '{32'd3, 32'd2, 32'd2, 32'd2};
    logic [31:0] t_hi[4] = '{32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'h1};
    logic [31:0] t_lo[4] = '{32'hFFFFFFFA, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h3};
    int          t_n[4]  = '{5, 5, 10, 10};
    mif.d_md_use = 1'b1;
    for (int t = 0; t < 4; t++) begin
      mif.op = t_op[t]; mif.start = 1'b1; mif.a = t_a[t]; mif.b = t_b[t];
      #1;
      n_chk++; if (mif.stall !== 1'b1) begin n_fail++; $display("FAIL arith%0d_start_stall got %h want 1", t, mif.stall); end
      issue(t_op[t], t_a[t], t_b[t]);
      for (int c = 0; c < t_n[t]; c++) begin
        n_chk++; if (mif.busy !== 1'b1) begin n_fail++; $display("FAIL arith%0d_busy c%0d got %h want 1", t, c, mif.busy); end
        n_chk++; if (mif.stall !== 1'b1) begin n_fail++; $display("FAIL arith%0d_stall c%0d got %h want 1", t, c, mif.stall); end
        n_chk++; if (mif.hi !== exp_hi) begin n_fail++; $display("FAIL arith%0d_hold_hi c%0d got %h want %h", t, c, mif.hi, exp_hi); end
        tick();
      end
      n_chk++; if (mif.busy !== 1'b0) begin n_fail++; $display("FAIL arith%0d_done_busy got %h want 0", t, mif.busy); end
      n_chk++; if (mif.stall !== 1'b0) begin n_fail++; $display("FAIL arith%0d_done_stall got %h want 0", t, mif.stall); end
      n_chk++; if (mif.hi !== t_hi[t]) begin n_fail++; $display("FAIL arith%0d_hi got %h want %h", t, mif.hi, t_hi[t]); end
      n_chk++; if (mif.lo !== t_lo[t]) begin n_fail++; $display("FAIL arith%0d_lo got %h want %h", t, mif.lo, t_lo[t]); end
      exp_hi = t_hi[t]; exp_lo = t_lo[t];
    end
    mif.d_md_use = 1'b0;
  endtask

  task automatic test_mt_divzero();
    mif.op = 3'd5; mif.a = 32'h11;
    tick();
    n_chk++; if (mif.hi !== 32'h11) begin n_fail++; $display("FAIL mthi got %h want 11", mif.hi); end
    n_chk++; if (mif.busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy got %h want 0", mif.busy); end
    mif.op = 3'd6; mif.a = 32'h22;
    tick();
    mif.op = 3'd0;
    n_chk++; if (mif.lo !== 32'h22) begin n_fail++; $display("FAIL mtlo got %h want 22", mif.lo); end
    n_chk++; if (mif.busy !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy got %h want 0", mif.busy); end
    issue(3'd4, 32'd1234, 32'd0);
    for (int c = 0; c < 10; c++) begin
      n_chk++; if (mif.busy !== 1'b1) begin n_fail++; $display("FAIL divz_busy c%0d got %h want 1", c, mif.busy); end
      tick();
    end
    n_chk++; if (mif.busy !== 1'b0) begin n_fail++; $display("FAIL divz_done got %h want 0", mif.busy); end
    n_chk++; if (mif.hi !== 32'h11) begin n_fail++; $display("FAIL divz_hi got %h want 11", mif.hi); end
    n_chk++; if (mif.lo !== 32'h22) begin n_fail++; $display("FAIL divz_lo got %h want 22", mif.lo); end
    exp_hi = 32'h11; exp_lo = 32'h22;
  endtask

  task automatic test_ignore_busy();
    issue(3'd1, 32'd3, 32'd5);
    tick();
    mif.op = 3'd5; mif.a = 32'h55;
    tick();
    mif.op = 3'd3; mif.start = 1'b1; mif.a = 32'd100; mif.b = 32'd7;
    tick();
    mif.op = 3'd0; mif.start = 1'b0;
    tick();
    n_chk++; if (mif.busy !== 1'b1) begin n_fail++; $display("FAIL ign_busy4 got %h want 1", mif.busy); end
    n_chk++; if (mif.hi !== 32'h11) begin n_fail++; $display("FAIL ign_mthi got %h want 11", mif.hi); end
    tick();
    n_chk++; if (mif.busy !== 1'b0) begin n_fail++; $display("FAIL ign_busy5 got %h want 0", mif.busy); end
    n_chk++; if (mif.hi !== 32'd0) begin n_fail++; $display("FAIL ign_hi got %h want 0", mif.hi); end
    n_chk++; if (mif.lo !== 32'd15) begin n_fail++; $display("FAIL ign_lo got %h want f", mif.lo); end
    for (int c = 0; c < 8; c++) begin
      tick();
      n_chk++; if (mif.busy !== 1'b0 || mif.lo !== 32'd15) begin
        n_fail++; $display("FAIL ign_after c%0d busy %h lo %h want 0 f", c, mif.busy, mif.lo);
      end
    end
    exp_hi = 0; exp_lo = 32'd15;
  endtask

  task automatic test_reset_abort();
    issue(3'd3, 32'd100, 32'd7);
    tick(); tick(); tick();
    reset = 1'b1; mif.d_md_use = 1'b1;
    tick();
    reset = 1'b0;
    n_chk++; if (mif.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %h want 0", mif.busy); end
    n_chk++; if (mif.hi !== 32'd0 || mif.lo !== 32'd0) begin
      n_fail++; $display("FAIL abort_hilo got %h %h want 0 0", mif.hi, mif.lo);
    end
    n_chk++; if (mif.stall !== 1'b0) begin n_fail++; $display("FAIL abort_stall got %h want 0", mif.stall); end
    mif.start = 1'b1; mif.op = 3'd0;
    #1;
    n_chk++; if (mif.stall !== 1'b1) begin n_fail++; $display("FAIL abort_stall_start got %h want 1", mif.stall); end
    mif.start = 1'b0; mif.d_md_use = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_chk++; if (mif.busy !== 1'b0 || mif.hi !== 32'd0 || mif.lo !== 32'd0) begin
        n_fail++; $display("FAIL abort_after c%0d busy %h hi %h lo %h want 0", c, mif.busy, mif.hi, mif.lo);
      end
    end
    exp_hi = 0; exp_lo = 0;
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b, nh, nl;
    logic        use_r;
    for (int it = 0; it < 40; it++) begin
      op = 3'($urandom_range(1, 6));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9)) ^ {32{b[31]}};
        default: ;
      endcase
      use_r = 1'($urandom_range(0, 1));
      mif.d_md_use = use_r;
      if (op >= 3'd5) begin
        mif.op = op; mif.a = a; mif.b = b;
        tick();
        mif.op = 3'd0;
        if (op == 3'd5) exp_hi = a; else exp_lo = a;
        n_chk++; if (mif.busy !== 1'b0 || mif.hi !== exp_hi || mif.lo !== exp_lo) begin
          n_fail++; $display("FAIL rnd%0d_mt op%0d busy %h hi %h lo %h want 0 %h %h", it, op, mif.busy, mif.hi, mif.lo, exp_hi, exp_lo);
        end
      end else begin
        nh = exp_hi; nl = exp_lo;
        ref_md(op, a, b, nh, nl);
        issue(op, a, b);
        for (int c = 0; c < ncyc(op); c++) begin
          n_chk++; if (mif.busy !== 1'b1 || mif.stall !== use_r || mif.hi !== exp_hi || mif.lo !== exp_lo) begin
            n_fail++; $display("FAIL rnd%0d_run c%0d busy %h stall %h hi %h lo %h want 1 %h %h %h", it, c, mif.busy, mif.stall, mif.hi, mif.lo, use_r, exp_hi, exp_lo);
          end
          tick();
        end
        n_chk++; if (mif.busy !== 1'b0 || mif.hi !== nh || mif.lo !== nl) begin
          n_fail++; $display("FAIL rnd%0d_res op%0d a %h b %h busy %h hi %h lo %h want 0 %h %h", it, op, a, b, mif.busy, mif.hi, mif.lo, nh, nl);
        end
        exp_hi = nh; exp_lo = nl;
      end
    end
    mif.d_md_use = 1'b0;
  endtask

  initial begin
    mif.op = 3'd0; mif.start = 1'b0; mif.a = 32'd0; mif.b = 32'd0; mif.d_md_use = 1'b0;
    exp_hi = 0; exp_lo = 0;
    test_reset();
    test_arith();
    test_mt_divzero();
    test_ignore_busy();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
